// File: rtl/logo_command_assembler_pkg.sv
// Shared constants for the LOGO command assembler: buffer size defaults,
// PS2 set-2 prefix/control scancodes and the main FSM state encoding.
package logo_command_assembler_pkg;

    localparam int CMD_CHARS_DEF = 4;
    localparam int CNT_W_DEF     = 3;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/logo_command_assembler_scancode_to_ascii.sv
// Combinational PS2 set-2 make code to ASCII lookup; letters are upper case,
// unmapped codes return 0 so the caller can drop them.
module scancode_to_ascii (
    input  logic [7:0] scancode,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scancode)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/logo_command_assembler.sv
// Assembles PS2 keystrokes into a LOGO command word and hands it to the
// processor over valid/ready, echoing each accepted character to the LCD.
//
// state   | meaning
// COLLECT | buffering characters, Enter with a non-empty buffer publishes
// HOLD    | cmd_word presented, keys dropped until cmd_ready
module logo_command_assembler
    import logo_command_assembler_pkg::*;
#(
    parameter int CMD_CHARS = CMD_CHARS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             key_data,
    input  logic                   key_pressed,
    input  logic                   cmd_ready,
    output logic [8*CMD_CHARS-1:0] cmd_word,
    output logic                   cmd_valid,
    output logic [CNT_W-1:0]       char_count,
    output logic                   overflow,
    output logic [7:0]             echo_char,
    output logic                   echo_valid
);

    localparam int BUF_W = 8 * CMD_CHARS;

    state_t             state, state_nxt;
    logic [BUF_W-1:0]   buffer, buffer_nxt;
    logic [BUF_W-1:0]   word_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               ovf_nxt;
    logic [7:0]         echo_char_nxt;
    logic               echo_valid_nxt;
    logic               break_pending, break_nxt;
    logic               ext_pending, ext_nxt;
    logic               is_enter, is_make;
    logic [7:0]         ascii;

    scancode_to_ascii u_map (
        .scancode (key_data),
        .ascii    (ascii)
    );

    assign cmd_valid = (state == HOLD);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= COLLECT;
            buffer        <= '0;
            cmd_word      <= '0;
            char_count    <= '0;
            overflow      <= 1'b0;
            echo_char     <= 8'h00;
            echo_valid    <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            state         <= state_nxt;
            buffer        <= buffer_nxt;
            cmd_word      <= word_nxt;
            char_count    <= count_nxt;
            overflow      <= ovf_nxt;
            echo_char     <= echo_char_nxt;
            echo_valid    <= echo_valid_nxt;
            break_pending <= break_nxt;
            ext_pending   <= ext_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        buffer_nxt     = buffer;
        word_nxt       = cmd_word;
        count_nxt      = char_count;
        ovf_nxt        = overflow;
        echo_char_nxt  = echo_char;
        echo_valid_nxt = 1'b0;
        break_nxt      = break_pending;
        ext_nxt        = ext_pending;
        is_enter       = 1'b0;
        is_make        = 1'b0;

        // Prefix decode runs in every state; break sequences swallow the next byte.
        if (key_pressed) begin
            if (key_data == SC_BREAK) begin
                break_nxt = 1'b1;
            end else if (key_data == SC_EXT) begin
                ext_nxt = 1'b1;
            end else begin
                break_nxt = 1'b0;
                ext_nxt   = 1'b0;
                if (!break_pending) begin
                    is_enter = (key_data == SC_ENTER);
                    is_make  = !ext_pending && (key_data != SC_ENTER);
                end
            end
        end

        case (state)
            COLLECT: begin
                if (is_enter) begin
                    if (char_count != '0) begin
                        word_nxt  = buffer;
                        state_nxt = HOLD;
                    end
                end else if (is_make) begin
                    if (key_data == SC_BKSP) begin
                        if (char_count != '0) begin
                            buffer_nxt = buffer >> 8;
                            count_nxt  = char_count - CNT_W'(1);
                        end
                    end else if (ascii != 8'h00) begin
                        if (char_count < CNT_W'(CMD_CHARS)) begin
                            buffer_nxt     = {buffer[BUF_W-9:0], ascii};
                            count_nxt      = char_count + CNT_W'(1);
                            echo_char_nxt  = ascii;
                            echo_valid_nxt = 1'b1;
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    state_nxt  = COLLECT;
                    buffer_nxt = '0;
                    count_nxt  = '0;
                    ovf_nxt    = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: doc/logo_command_assembler.md
Name: logo_command_assembler

Overview:
- Sits directly downstream of the PS2 keyboard interface and upstream of the processor's LOGO command input.
- Consumes raw set-2 scancode bytes and strips break (F0) and extended (E0) sequences.
- Maps make codes to ASCII and assembles up to CMD_CHARS characters into a command word; supports backspace and an overflow flag.
- On Enter, presents the word to the processor through a valid/ready handshake, and echoes each accepted character to the LCD path.

Parameters:
- CMD_CHARS, 4, maximum characters per command; cmd_word width is 8*CMD_CHARS.
- CNT_W, 3, width of char_count; must hold values 0..CMD_CHARS.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_data  in  8  raw PS2 scancode byte.
- key_pressed  in  1  one-cycle strobe; key_data is valid in that cycle.
- cmd_ready  in  1  consumer accepts cmd_word when high together with cmd_valid.
- cmd_word  out  8*CMD_CHARS  assembled command; last-typed char in [7:0], unused upper bytes zero.
- cmd_valid  out  1  command available; held until accepted.
- char_count  out  CNT_W  characters currently buffered.
- overflow  out  1  sticky; a character was dropped because the buffer was full.
- echo_char  out  8  ASCII of the most recently accepted character.
- echo_valid  out  1  one-cycle pulse when echo_char updates.

Behaviour:
- Reset (asynchronous, resetn low): all outputs 0, buffer 0, break_pending=0, ext_pending=0, state COLLECT. Reset mid-HOLD discards the pending command.
- Prefix tracking is independent of the main FSM and active in every state, evaluated only on key_pressed:
  - 0xF0: set break_pending.
  - 0xE0: set ext_pending.
  - Any other byte with break_pending=1 is consumed silently and clears both flags.
  - Any other byte with ext_pending=1 (no break) is an extended make: only 0x5A (keypad Enter) is honoured, as Enter; all others are dropped. Both flags clear.
- Main FSM states: COLLECT, HOLD.
- COLLECT, plain make code:
  - 0x5A Enter, char_count>0: cmd_word<=buffer, cmd_valid<=1, go HOLD. Buffer is kept until the handshake.
  - 0x5A Enter, char_count==0: ignored.
  - 0x66 Backspace, char_count>0: buffer logically shifts right 8 bits (zero fill), char_count-1. At count 0: ignored. No echo.
  - Mapped ASCII nonzero, char_count<CMD_CHARS: buffer<={buffer[8*CMD_CHARS-9:0], ascii}, char_count+1, echo_char<=ascii, echo_valid pulse.
  - Mapped ASCII nonzero, char_count==CMD_CHARS: dropped, overflow<=1, no echo.
  - Mapped ASCII zero (unsupported key): dropped, no flag.
- HOLD:
  - cmd_valid=1; cmd_word stable.
  - All make codes are dropped (no buffer, count, echo or overflow change); prefix tracking still runs.
  - When cmd_valid&&cmd_ready: next cycle cmd_valid=0, buffer=0, char_count=0, overflow=0, state COLLECT.
  - A key_pressed in the handshake cycle is treated as arriving in HOLD (dropped).
- Latency: key_pressed at edge t → buffer/char_count/echo/cmd_valid visible after edge t+1 (one register stage). Handshake clear is also one cycle.
- Typematic repeats are new make codes and are accepted as characters.
- cmd_valid never deasserts without cmd_ready, except on reset.

Decomposition:
- Shared package: CMD_CHARS default, and scancode constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_ENTER=0x5A, SC_BKSP=0x66. FSM state encoding COLLECT=0, HOLD=1.
- One combinational sub-module, scancode_to_ascii (8-bit scancode in, 8-bit ASCII out, 0 if unmapped):
  - A–Z → 0x41–0x5A, e.g. 1C→41, 32→42, 21→43, 23→44, 24→45, 2B→46.
  - 0–9 → 0x30–0x39, e.g. 45→30, 16→31.
  - Space 0x29 → 0x20.
- The top contains the prefix flags, buffer/count datapath, FSM and handshake.

Test Plan:
- Strobe 2B, F0, 2B, 23, F0, 23, 5A with cmd_ready=0 → cmd_word=0x00004644, cmd_valid=1 held, char_count=2, two echo pulses (0x46, 0x44). Then cmd_ready=1 for one cycle → cmd_valid=0, char_count=0.
- Strobe F0, 1C only → no echo, char_count=0, buffer unchanged. Then E0, 75 (up arrow) → dropped. Then E0, 5A with empty buffer → no cmd_valid.
- Strobe 1C, 32, 66, then 5A → cmd_word=0x00000041, char_count=1 before Enter.
- Strobe 1C, 32, 21, 23, 24 → buffer 0x41424344, char_count=4, overflow=1, no echo for 0x45. Then E0, 5A → cmd_word=0x41424344. After handshake, overflow=0.
- In HOLD, strobe 24 → cmd_word unchanged, no echo. Assert cmd_ready in the same cycle as key_pressed=1C → command accepted, char_count=0 afterwards, 0x41 not buffered.
- Drive resetn low asynchronously mid-HOLD → cmd_valid, cmd_word, char_count, overflow and echo_valid are 0 before the next clock edge. Release, then strobe 1C, 5A → cmd_word=0x00000041.
